// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared data RAM between instruction fetch (IF) and load/store (DM) ports.
// Optional macro MISALIGN_CHECK_EN: misaligned DM accesses are answered with dm_err, skipping the RAM.
module mem_port_arbiter #(
  parameter int ADDR_W      = 10,
  parameter bit DM_PRIORITY = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [31:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_funct3,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [63:0]       dm_wdata,
  output logic              dm_ready,
  output logic [63:0]       dm_rdata,
  output logic              dm_err,
  output logic              ram_we,
  output logic [31:0]       ram_inst,
  output logic [ADDR_W-1:0] ram_address,
  output logic [63:0]       ram_write_data,
  input  logic [63:0]       ram_read_data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_dm_q, last_dm_d;
  logic              gnt_dm_q, gnt_dm_d;
  logic              lat_we_q, lat_we_d;
  logic [2:0]        lat_f3_q, lat_f3_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [63:0]       lat_wdata_q, lat_wdata_d;
  logic              err_q, err_d;
  logic [63:0]       dm_rdata_q, dm_rdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              pick_dm;
  logic              misaligned;
  logic              in_access;
  logic              in_resp;

  // On a tie, round-robin grants whichever port did not win last time.
  always_comb begin
    if (if_req && dm_req) pick_dm = DM_PRIORITY ? 1'b1 : !last_dm_q;
    else                  pick_dm = dm_req;
  end

`ifdef MISALIGN_CHECK_EN
  always_comb begin
    case (dm_funct3[1:0])
      2'b01:   misaligned = dm_addr[0];
      2'b10:   misaligned = |dm_addr[1:0];
      2'b11:   misaligned = |dm_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    last_dm_d   = last_dm_q;
    gnt_dm_d    = gnt_dm_q;
    lat_we_d    = lat_we_q;
    lat_f3_d    = lat_f3_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    err_d       = err_q;
    dm_rdata_d  = dm_rdata_q;
    if_rdata_d  = if_rdata_q;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          gnt_dm_d   = pick_dm;
          last_dm_d  = pick_dm;
          lat_addr_d = pick_dm ? dm_addr : if_addr;
          lat_we_d   = pick_dm & dm_we;
          lat_f3_d   = pick_dm ? dm_funct3 : 3'b110;
          if (pick_dm) lat_wdata_d = dm_wdata;
          err_d      = pick_dm & misaligned;
          state_d    = (pick_dm && misaligned) ? RESP : ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        if (gnt_dm_q) begin
          if (!lat_we_q && !err_q) dm_rdata_d = ram_read_data;
        end else begin
          if_rdata_d = ram_read_data[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= IDLE;
      last_dm_q   <= 1'b1;
      gnt_dm_q    <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_f3_q    <= '0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      err_q       <= 1'b0;
      dm_rdata_q  <= '0;
      if_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_dm_q   <= last_dm_d;
      gnt_dm_q    <= gnt_dm_d;
      lat_we_q    <= lat_we_d;
      lat_f3_q    <= lat_f3_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      err_q       <= err_d;
      dm_rdata_q  <= dm_rdata_d;
      if_rdata_q  <= if_rdata_d;
    end
  end

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);

  // The RAM read data is only present during RESP, so outputs bypass it there and hold afterwards.
  assign if_ready = in_resp & !gnt_dm_q;
  assign dm_ready = in_resp & gnt_dm_q;
  assign dm_err   = dm_ready & err_q;
  assign dm_rdata = (dm_ready && !lat_we_q && !err_q) ? ram_read_data : dm_rdata_q;
  assign if_rdata = if_ready ? ram_read_data[31:0] : if_rdata_q;

  assign ram_we         = in_access & lat_we_q & rstn;
  assign ram_inst       = in_access ? {17'b0, lat_f3_q, 5'b0, (lat_we_q ? 7'b0100011 : 7'b0000011)} : '0;
  assign ram_address    = lat_addr_q;
  assign ram_write_data = lat_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a byte-array RAM, a transaction-level reference model and literal directed checks.
module tb_mem_port_arbiter;
  localparam bit DMP = 1'b0;
`ifdef MISALIGN_CHECK_EN
  localparam bit MCHK = 1'b1;
`else
  localparam bit MCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn, if_req, dm_req, dm_we;
  logic [9:0]  if_addr, dm_addr, ram_address;
  logic [2:0]  dm_funct3;
  logic [63:0] dm_wdata, dm_rdata, ram_write_data, ram_read_data;
  logic [31:0] if_rdata, ram_inst;
  logic        if_ready, dm_ready, dm_err, ram_we;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(10), .DM_PRIORITY(DMP)) dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .ram_we(ram_we), .ram_inst(ram_inst), .ram_address(ram_address),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ld_ext(input logic [63:0] raw, input logic [2:0] f3);
    int unsigned nb;
    logic [63:0] mask;
    logic [63:0] v;
    nb = 1 << f3[1:0];
    v = raw;
    if (nb < 8) begin
      mask = (64'd1 << (8 * nb)) - 64'd1;
      v = raw & mask;
      if (!f3[2] && v[8*nb-1]) v = v | ~mask;
    end
    return v;
  endfunction

  // Environment RAM: byte array, registered read.
  logic [7:0] ram_mem [1024];
  always @(posedge clk) begin
    logic [63:0] raw;
    if (ram_we && !ram_inst[14])
      for (int i = 0; i < (1 << ram_inst[13:12]); i++)
        ram_mem[int'(ram_address) + i] <= ram_write_data[8*i +: 8];
    if (ram_inst[6:0] == 7'b0000011) begin
      raw = '0;
      for (int i = 0; i < 8; i++)
        if (int'(ram_address) + i < 1024) raw[8*i +: 8] = ram_mem[int'(ram_address) + i];
      ram_read_data <= ld_ext(raw, ram_inst[14:12]);
    end
  end

  // Reference model: one outstanding transaction, response timing from the accept edge.
  logic [7:0]  mm [1024];
  int          cyc = 0;
  bit          m_valid = 0, m_busy = 0, m_dm, m_we, m_err, m_last_dm;
  int          m_acc, m_resp;
  logic [2:0]  m_f3;
  logic [9:0]  m_addr, e_addr;
  logic [63:0] m_wd, e_dm_rdata;
  logic [31:0] e_if_rdata;
  bit          e_if_ready = 0, e_dm_ready = 0, e_dm_err = 0;

  function automatic logic [63:0] mm_load(input logic [9:0] a, input logic [2:0] f3);
    logic [63:0] raw = '0;
    for (int i = 0; i < 8; i++)
      if (int'(a) + i < 1024) raw[8*i +: 8] = mm[int'(a) + i];
    return ld_ext(raw, f3);
  endfunction

  always @(posedge clk) begin
    int unsigned nb;
    cyc++;
    e_if_ready = 0; e_dm_ready = 0; e_dm_err = 0;
    if (!rstn) begin
      m_valid = 1; m_busy = 0; m_last_dm = 1;
      e_dm_rdata = '0; e_if_rdata = '0; e_addr = '0;
    end else begin
      if (m_busy && cyc == m_resp + 2) m_busy = 0;
      if (!m_busy && (if_req || dm_req)) begin
        m_dm = (if_req && dm_req) ? (DMP ? 1'b1 : !m_last_dm) : dm_req;
        m_last_dm = m_dm;
        m_addr = m_dm ? dm_addr : if_addr;
        m_we   = m_dm && dm_we;
        m_f3   = m_dm ? dm_funct3 : 3'b110;
        m_wd   = dm_wdata;
        nb     = 1 << m_f3[1:0];
        m_err  = MCHK && m_dm && (int'(m_addr) % nb != 0);
        m_acc  = cyc;
        m_resp = m_err ? cyc : cyc + 1;
        m_busy = 1;
        e_addr = m_addr;
      end
      if (m_busy && cyc == m_resp) begin
        if (!m_err) begin
          if (m_dm && m_we) begin
            if (!m_f3[2])
              for (int i = 0; i < (1 << m_f3[1:0]); i++) mm[int'(m_addr) + i] = m_wd[8*i +: 8];
          end else if (m_dm) e_dm_rdata = mm_load(m_addr, m_f3);
          else e_if_rdata = mm_load(m_addr, 3'b110) & 32'hFFFF_FFFF;
        end
        if (m_dm) begin e_dm_ready = 1; e_dm_err = m_err; end
        else e_if_ready = 1;
      end
    end
  end

  always @(negedge clk) begin
    bit acc;
    if (m_valid) begin
      acc = m_busy && !m_err && (cyc == m_acc);
      chk("if_ready", if_ready, e_if_ready);
      chk("dm_ready", dm_ready, e_dm_ready);
      chk("dm_err", dm_err, e_dm_err);
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("dm_rdata", dm_rdata, e_dm_rdata);
      chk("ram_we", ram_we, acc && m_we && rstn);
      chk("ram_inst", ram_inst, acc ? {17'b0, m_f3, 5'b0, (m_we ? 7'b0100011 : 7'b0000011)} : 32'h0);
      chk("ram_address", ram_address, e_addr);
      if (acc && m_we) chk("ram_write_data", ram_write_data, m_wd);
    end
  end

  task automatic dm_txn(input bit we, input logic [2:0] f3, input logic [9:0] a, input logic [63:0] wd,
                        input int exp_lat, input bit chk_data, input logic [63:0] exp_data,
                        input bit exp_err, input bit exp_we_seen, input string nm);
    int k = 0;
    bit got = 0, seen_we = 0;
    @(posedge clk); #2;
    dm_req = 1; dm_we = we; dm_funct3 = f3; dm_addr = a; dm_wdata = wd;
    while (!got && k < 12) begin
      @(negedge clk); k++;
      if (ram_we) seen_we = 1;
      if (dm_ready) got = 1;
    end
    chk({nm, "_ready"}, got, 1);
    chk({nm, "_latency"}, k, exp_lat);
    if (chk_data) chk({nm, "_data"}, dm_rdata, exp_data);
    chk({nm, "_err"}, dm_err, exp_err);
    chk({nm, "_ram_we_seen"}, seen_we, exp_we_seen);
    dm_req = 0;
  endtask

  task automatic if_txn(input logic [9:0] a, input logic [31:0] exp_data, input string nm);
    int k = 0;
    bit got = 0, seen_dm = 0;
    @(posedge clk); #2;
    if_req = 1; if_addr = a;
    while (!got && k < 12) begin
      @(negedge clk); k++;
      if (dm_ready) seen_dm = 1;
      if (if_ready) got = 1;
    end
    chk({nm, "_ready"}, got, 1);
    chk({nm, "_latency"}, k, 3);
    chk({nm, "_data"}, if_rdata, exp_data);
    chk({nm, "_dm_ready_seen"}, seen_dm, 0);
    if_req = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2; rstn = 0;
    @(posedge clk); @(posedge clk); #2; rstn = 1;
  endtask

  initial begin
    int seq[$];
    bit seen;
    int unsigned nb;
    for (int i = 0; i < 1024; i++) begin ram_mem[i] = '0; mm[i] = '0; end
    ram_read_data = '0;
    rstn = 0; if_req = 0; dm_req = 0; dm_we = 0; dm_funct3 = '0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    do_reset();
    @(negedge clk);
    chk("rst_if_ready", if_ready, 0);
    chk("rst_dm_ready", dm_ready, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ram_inst", ram_inst, 0);

    dm_txn(1, 3'b011, 10'h010, 64'h1122334455667788, 3, 0, 0, 0, 1, "sd");
    dm_txn(0, 3'b011, 10'h010, 0, 3, 1, 64'h1122334455667788, 0, 0, "ld");
    if_txn(10'h010, 32'h55667788, "fetch");
    dm_txn(1, 3'b000, 10'h020, 64'h80, 3, 0, 0, 0, 1, "sb");
    dm_txn(0, 3'b000, 10'h020, 0, 3, 1, 64'hFFFFFFFFFFFFFF80, 0, 0, "lb");
    dm_txn(0, 3'b100, 10'h020, 0, 3, 1, 64'h80, 0, 0, "lbu");
    dm_txn(1, 3'b010, 10'h002, 64'hDEADBEEF, MCHK ? 2 : 3, 0, 0, MCHK, !MCHK, "sw_misaligned");

    // Store cut off by reset while in ACCESS.
    dm_txn(1, 3'b010, 10'h040, 64'h12345678, 3, 0, 0, 0, 1, "sw_a");
    @(posedge clk); #2;
    dm_req = 1; dm_we = 1; dm_funct3 = 3'b010; dm_addr = 10'h040; dm_wdata = 64'hCAFEF00D;
    @(posedge clk); #2; rstn = 0; dm_req = 0;
    @(negedge clk);
    chk("rst_in_access_ram_we", ram_we, 0);
    @(posedge clk); #2; rstn = 1;
    seen = 0;
    repeat (4) begin @(negedge clk); if (dm_ready) seen = 1; end
    chk("rst_in_access_no_ready", seen, 0);
    dm_txn(0, 3'b010, 10'h040, 0, 3, 1, 64'h12345678, 0, 0, "lw_after_reset");

    // Both ports held from reset.
    do_reset();
    @(posedge clk); #2;
    if_req = 1; if_addr = 10'h010; dm_req = 1; dm_we = 0; dm_funct3 = 3'b011; dm_addr = 10'h010;
    for (int k = 0; k < 40 && seq.size() < 6; k++) begin
      @(negedge clk);
      if (if_ready) seq.push_back(0);
      if (dm_ready) seq.push_back(1);
    end
    if_req = 0; dm_req = 0;
    chk("tie_grant_count", seq.size(), 6);
    foreach (seq[i]) chk($sformatf("tie_grant_%0d", i), seq[i], DMP ? 1 : (i % 2));

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      rstn = ($urandom_range(0, 199) != 0);
      if (if_req) begin if (e_if_ready && $urandom_range(0, 4) != 0) if_req = 0; end
      else if_req = ($urandom_range(0, 2) == 0);
      if (dm_req) begin if (e_dm_ready && $urandom_range(0, 4) != 0) dm_req = 0; end
      else dm_req = ($urandom_range(0, 2) == 0);
      if_addr   = 10'($urandom_range(0, 31) * 4);
      dm_we     = $urandom_range(0, 1);
      dm_funct3 = dm_we ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 6));
      nb        = 1 << dm_funct3[1:0];
      dm_addr   = 10'($urandom_range(0, 127));
      if ($urandom_range(0, 1) != 0) dm_addr = dm_addr & ~10'(nb - 1);
      dm_wdata  = {$urandom, $urandom};
    end
    @(posedge clk); #2; rstn = 1; if_req = 0; dm_req = 0;
    repeat (6) @(posedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
